// File: rtl/fp_op_controller.sv
// Control sequencer for the single-precision add/sub/mult datapath: steps one
// request through compare, align, ALU, rounding check and optional renormalisation.
module fp_op_controller #(
    parameter int MAX_SHIFT  = 27,
    parameter int MAX_RENORM = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op_in,
    input  logic [7:0]  exp_diff,
    input  logic        carry,
    input  logic [26:0] frac_result,
    output logic        smaller_exp_src,
    output logic [7:0]  shift_right_qtt,
    output logic [1:0]  operation,
    output logic        normalization_src,
    output logic        shift_src,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CNT_W = (MAX_RENORM < 1) ? 1 : $clog2(MAX_RENORM + 1);
    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        ALIGN,
        ALU,
        RND_CHK,
        RENORM,
        DONE
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [1:0]       opReg;
    logic [1:0]       opNext;
    logic [CNT_W-1:0] renormCnt;
    logic [CNT_W-1:0] renormCntNext;
    logic             smallerNext;
    logic [7:0]       qttNext;
    logic [1:0]       operationNext;
    logic             normSrcNext;
    logic             shiftSrcNext;
    logic             errNext;
    logic             unusedFracBits;

    // Only the hidden-bit position of the fraction steers the sequence.
    assign unusedFracBits = ^frac_result[25:0];

    // Alignment amount: |expA-expB| taken in 9 bits so -128 stays representable,
    // then clamped to the point where the whole fraction is shifted out.
    function automatic logic [7:0] satShift(input logic signed [7:0] diff);
        logic signed [8:0] wide;
        logic [8:0]        mag;
        wide = {diff[7], diff};
        mag  = diff[7] ? $unsigned(-wide) : $unsigned(wide);
        if (mag > 9'(MAX_SHIFT)) begin
            satShift = 8'(MAX_SHIFT);
        end else begin
            satShift = mag[7:0];
        end
    endfunction

    always_comb begin
        stateNext     = state;
        opNext        = opReg;
        renormCntNext = renormCnt;
        smallerNext   = smaller_exp_src;
        qttNext       = shift_right_qtt;
        operationNext = operation;
        normSrcNext   = normalization_src;
        shiftSrcNext  = shift_src;
        errNext       = err;

        unique case (state)
            IDLE: begin
                if (start) begin
                    opNext        = op_in;
                    errNext       = 1'b0;
                    renormCntNext = '0;
                    stateNext     = CMP;
                end
            end
            CMP: begin
                if (opReg == OP_RSVD) begin
                    errNext   = 1'b1;
                    stateNext = DONE;
                end else begin
                    if (opReg == OP_MULT) begin
                        smallerNext = 1'b0;
                        qttNext     = 8'd0;
                    end else begin
                        smallerNext = ~exp_diff[7];
                        qttNext     = satShift(exp_diff);
                    end
                    stateNext = ALIGN;
                end
            end
            ALIGN: begin
                operationNext = opReg;
                normSrcNext   = 1'b1;
                stateNext     = ALU;
            end
            ALU: begin
                // Carry out of the big ALU means the sum overflowed: normalise right.
                shiftSrcNext = carry;
                normSrcNext  = 1'b0;
                stateNext    = RND_CHK;
            end
            RND_CHK: begin
                if (!frac_result[26] && (renormCnt < CNT_W'(MAX_RENORM))) begin
                    shiftSrcNext  = 1'b1;
                    normSrcNext   = 1'b0;
                    renormCntNext = renormCnt + CNT_W'(1);
                    stateNext     = RENORM;
                end else begin
                    stateNext = DONE;
                end
            end
            RENORM: begin
                stateNext = RND_CHK;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // busy and done are derived from the next state so they line up with it exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            opReg             <= 2'b00;
            renormCnt         <= '0;
            smaller_exp_src   <= 1'b0;
            shift_right_qtt   <= 8'd0;
            operation         <= 2'b00;
            normalization_src <= 1'b0;
            shift_src         <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
        end else begin
            state             <= stateNext;
            opReg             <= opNext;
            renormCnt         <= renormCntNext;
            smaller_exp_src   <= smallerNext;
            shift_right_qtt   <= qttNext;
            operation         <= operationNext;
            normalization_src <= normSrcNext;
            shift_src         <= shiftSrcNext;
            busy              <= (stateNext != IDLE);
            done              <= (stateNext == DONE);
            err               <= errNext;
        end
    end

endmodule

// File: tb/tb_fp_op_controller.sv
// Scoreboard bench for fp_op_controller: a timing-aware driver predicts each
// operation's controls and completion cycle; a monitor compares on every done pulse.
module tb_fp_op_controller;

    localparam int MAX_SHIFT  = 27;
    localparam int MAX_RENORM = 1;
    localparam int N_RANDOM   = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op_in = 2'b00;
    logic [7:0]  exp_diff = 8'h00;
    logic        carry = 1'b0;
    logic [26:0] frac_result = 27'd0;
    logic        smaller_exp_src;
    logic [7:0]  shift_right_qtt;
    logic [1:0]  operation;
    logic        normalization_src;
    logic        shift_src;
    logic        busy;
    logic        done;
    logic        err;

    fp_op_controller #(
        .MAX_SHIFT (MAX_SHIFT),
        .MAX_RENORM(MAX_RENORM)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .op_in            (op_in),
        .exp_diff         (exp_diff),
        .carry            (carry),
        .frac_result      (frac_result),
        .smaller_exp_src  (smaller_exp_src),
        .shift_right_qtt  (shift_right_qtt),
        .operation        (operation),
        .normalization_src(normalization_src),
        .shift_src        (shift_src),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; a state "at N+k" occupies the cycle ending with edge N+k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] op;
        logic       err;
        logic       smaller;
        logic [7:0] qtt;
        logic       shiftSrc;
        int         accept;
        int         doneE;
    } expect_t;

    expect_t sb[$];
    int      checks = 0;
    int      failures = 0;
    bit      monOn = 1'b0;
    bit      ctlChk = 1'b0;
    logic    lastErr = 1'b0;
    int      idleFrom = 0;
    bit      prevHold = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: busy/err every cycle, full control set on each done pulse.
    expect_t cur;
    bit      inOp;
    always @(negedge clk) begin
        if (monOn) begin
            inOp = (sb.size() > 0) && (cyc >= sb[0].accept);
            if (ctlChk) begin
                check("busy", busy, inOp);
                if (inOp) check("err", err, (cyc == sb[0].doneE) ? sb[0].err : 1'b0);
                else      check("err_held", err, lastErr);
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    cur = sb.pop_front();
                    check("done_cycle", cyc, cur.doneE);
                    check("err_at_done", err, cur.err);
                    if (cur.op != 2'b11) begin
                        check("smaller_exp_src", smaller_exp_src, cur.smaller);
                        check("shift_right_qtt", shift_right_qtt, cur.qtt);
                        check("operation", operation, cur.op);
                        check("shift_src", shift_src, cur.shiftSrc);
                        check("normalization_src", normalization_src, 1'b0);
                    end
                    lastErr = cur.err;
                end
            end else if ((sb.size() > 0) && (cyc > sb[0].doneE)) begin
                cur = sb.pop_front();
                check("done_by_deadline", done, 1'b1);
                lastErr = cur.err;
            end
        end
    end

    task automatic stepTo(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_smaller_exp_src"}, smaller_exp_src, 1'b0);
        check({tag, "_shift_right_qtt"}, shift_right_qtt, 8'd0);
        check({tag, "_operation"}, operation, 2'b00);
        check({tag, "_normalization_src"}, normalization_src, 1'b0);
        check({tag, "_shift_src"}, shift_src, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    // Issue one request once the model says the controller is idle; datapath
    // status is held for the whole operation, frac[26] constant throughout.
    task automatic issue(input logic [1:0] op, input logic [7:0] ed, input logic cy,
                         input logic f26, input bit hold, input bit spur);
        expect_t e;
        int d, mag, renorms, lat, gap;
        gap = prevHold ? 0 : int'($urandom_range(0, 2));
        stepTo(idleFrom + gap);
        start       = 1'b1;
        op_in       = op;
        exp_diff    = ed;
        carry       = cy;
        frac_result = {f26, 26'($urandom)};

        d       = int'($signed(ed));
        mag     = (d < 0) ? -d : d;
        renorms = f26 ? 0 : MAX_RENORM;
        e.op    = op;
        e.err   = (op == 2'b11);
        if (op == 2'b10) begin
            e.smaller = 1'b0;
            e.qtt     = 8'd0;
        end else begin
            e.smaller = (d >= 0);
            e.qtt     = (mag > MAX_SHIFT) ? 8'(MAX_SHIFT) : 8'(mag);
        end
        e.shiftSrc = (renorms > 0) ? 1'b1 : cy;
        lat        = (op == 2'b11) ? 2 : 5 + 2 * renorms;
        e.accept   = cyc + 1;
        e.doneE    = e.accept + lat - 1;
        sb.push_back(e);

        stepTo(e.accept);
        op_in = 2'($urandom);
        start = hold;
        if (!hold && spur) begin
            stepTo(e.accept + 1);
            start = 1'b1;
            stepTo(e.accept + 2);
            start = 1'b0;
        end
        idleFrom = e.doneE + 1;
        prevHold = hold;
    endtask

    logic [7:0] edgeDiffs [8] = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'h1B, 8'h1C, 8'hE5, 8'hE4};

    initial begin
        int a;
        logic [7:0] ed;
        @(negedge clk);
        stepTo(3);
        reset = 1'b0;
        checkIdle("por");
        monOn = 1'b1;

        // Reset held two cycles while the ALU step is active: abandoned, no done.
        start       = 1'b1;
        op_in       = 2'b00;
        exp_diff    = 8'h03;
        carry       = 1'b0;
        frac_result = {1'b1, 26'd0};
        a = cyc + 1;
        stepTo(a);
        start = 1'b0;
        stepTo(a + 2);
        reset = 1'b1;
        stepTo(a + 4);
        reset = 1'b0;
        checkIdle("reset_mid_op");
        stepTo(a + 12);
        ctlChk   = 1'b1;
        lastErr  = 1'b0;
        idleFrom = cyc;
        prevHold = 1'b0;

        issue(2'b00, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(2'b01, 8'hD8, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(2'b01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(2'b00, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(2'b00, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(2'b10, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(2'b11, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(2'b00, 8'hE5, 1'b1, 1'b1, 1'b1, 1'b0);
        issue(2'b01, 8'h1B, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(2'b11, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(2'b10, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(2'b00, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(2'b01, 8'hE4, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(2'b00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < N_RANDOM; i++) begin
            ed = ($urandom_range(0, 3) == 0) ? edgeDiffs[$urandom_range(0, 7)] : 8'($urandom);
            issue(2'($urandom), ed, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        if (prevHold) begin
            stepTo(idleFrom);
            start = 1'b0;
        end
        stepTo(idleFrom + 4);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        checks++;
        failures++;
        $display("FAIL watchdog: simulation reached cycle %0d without finishing, required completion earlier", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
